// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu - load/store initiator for the single-port data-memory BRAM.
//
// Takes one RV32I load/store request at a time from the MEM stage, validates
// it, drives the BRAM port in the accept cycle, waits out the BRAM's one-cycle
// read latency and returns an aligned, extended load result (or an error code)
// exactly two cycles after acceptance.
//
// Ports
//   clka        clock, rising edge (shared with BRAM clka)
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   high in IDLE: a request can be accepted this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I funct3 of the load/store
//   req_addr    byte address
//   req_wdata   store data (LSBs significant for SB/SH)
//   resp_valid  one-cycle response strobe
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
//   mem_en      BRAM ena
//   mem_we      BRAM wea (byte enables)
//   mem_addr    BRAM addra (word address)
//   mem_wdata   BRAM dina
//   mem_rdata   BRAM douta, valid the cycle after mem_en
// -----------------------------------------------------------------------------
module dmem_lsu #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clka,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [1:0]           resp_err,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_FUNCT3   = 2'b11
  } err_e;

  state_e      state_q, state_d;

  // Request attributes captured at acceptance, consumed in WAIT.
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  err_e        err_q;

  logic [31:0] resp_rdata_q, resp_rdata_d;
  err_e        resp_err_q, resp_err_d;

  logic        fire;
  err_e        req_err;
  logic        illegal_f3;
  logic        misaligned;
  logic        out_of_range;
  logic [3:0]  byte_en;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready = (state_q == S_IDLE);
  assign fire      = req_valid & req_ready;

  // ---------------------------------------------------------------------------
  // Request validation (priority: funct3 > alignment > range)
  // ---------------------------------------------------------------------------
  // Stores only have SB/SH/SW (000..010); loads lack 011, 110 and 111.
  assign illegal_f3   = req_we ? (req_funct3 > 3'b010)
                               : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign out_of_range = |req_addr[31:ADDR_BITS+2];

  always_comb begin
    if (illegal_f3)        req_err = ERR_FUNCT3;
    else if (misaligned)   req_err = ERR_MISALIGN;
    else if (out_of_range) req_err = ERR_RANGE;
    else                   req_err = ERR_OK;
  end

  // ---------------------------------------------------------------------------
  // BRAM drive: only in the accept cycle, and only for valid requests
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    byte_en   = 4'b1111;
    mem_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_en   = fire && (req_err == ERR_OK);
  assign mem_we   = (mem_en && req_we) ? byte_en : 4'b0000;
  assign mem_addr = req_addr[ADDR_BITS+1:2];

  // ---------------------------------------------------------------------------
  // Load alignment and extension (uses the captured request in WAIT)
  // ---------------------------------------------------------------------------
  assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_data = mem_rdata;
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_data = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
    if (we_q || (err_q != ERR_OK)) load_data = 32'h0;
  end

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> WAIT -> RESP -> IDLE, fixed two-cycle response latency
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: if (fire) state_d = S_WAIT;
      S_WAIT: begin
        resp_rdata_d = load_data;
        resp_err_d   = err_q;
        state_d      = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      err_q        <= ERR_OK;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      if (fire) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        err_q    <= req_err;
      end
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu - self-checking bench for dmem_lsu with a behavioural BRAM.
// Expected responses are queued when a request is accepted and compared when
// resp_valid appears, including the fixed two-cycle latency.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

  localparam int AB = 10;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AB-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       exp_en = 1'b0;
  logic [3:0] exp_we = 4'b0000;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

  dmem_lsu #(.ADDR_BITS(AB)) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  // Read-first single-port BRAM with byte write enables.
  logic [31:0] bram [0:(1<<AB)-1];
  always @(posedge clka) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  // Per-cycle monitor: BRAM enables and response scoreboard.
  always @(negedge clka) begin
    if (rst_n) begin
      check("mem_en", {31'h0, mem_en}, {31'h0, exp_en});
      check("mem_we", {28'h0, mem_we}, {28'h0, (exp_en ? exp_we : 4'b0000)});
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {30'h0, resp_err}, {30'h0, e.err});
          check("resp_latency", cyc - e.cyc, 32'd2);
        end
      end
    end
  end

  // Presents a request (req_valid left high) and returns once it is accepted.
  // Entered and left at 1 time unit after a rising edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic [1:0] exp_err, input logic [3:0] ewe,
                       input logic [31:0] ewd, output int acc_cyc);
    int n = 0;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    exp_en     = 1'b0;
    #1;
    while (!req_ready && n < 8) begin
      @(posedge clka);
      #1;
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      acc_cyc = -1;
      return;
    end
    exp_en = (exp_err == 2'b00);
    exp_we = we ? ewe : 4'b0000;
    if (exp_err == 2'b00) begin
      check("mem_addr", {22'h0, mem_addr}, (addr >> 2) & 32'h3FF);
      if (we) check("mem_wdata", mem_wdata, ewd);
    end
    sb_q.push_back('{exp_rd, exp_err, cyc});
    acc_cyc = cyc;
    @(posedge clka);
    #1;
    exp_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clka);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("resp_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic single(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input logic [1:0] exp_err, input logic [3:0] ewe,
                        input logic [31:0] ewd);
    int c;
    issue(we, f3, addr, wdata, exp_rd, exp_err, ewe, ewd, c);
    req_valid = 1'b0;
    drain();
    check("resp_hold", resp_rdata, exp_rd);
    check("resp_valid_low", {31'h0, resp_valid}, 32'd0);
  endtask

  initial begin
    int c1, c2, c3;

    repeat (3) @(posedge clka);
    #1;
    rst_n = 1'b1;
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {30'h0, resp_err}, 32'd0);

    // Store then loads of every width/extension.
    single(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00, 4'b1111, 32'hDEADBEEF);
    single(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 4'b0, 32'h0);

    // Sub-word stores.
    single(1'b1, 3'b000, 32'h13, 32'h00000012, 32'h0, 2'b00, 4'b1000, 32'h12121212);
    single(1'b0, 3'b010, 32'h10, 32'h0, 32'h12ADBEEF, 2'b00, 4'b0, 32'h0);
    single(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'h0, 2'b00, 4'b1100, 32'hABCDABCD);
    single(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFABCD, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b010, 32'h10, 32'h0, 32'hABCDBEEF, 2'b00, 4'b0, 32'h0);

    // Error requests, including priority cases.
    single(1'b0, 3'b010, 32'h12,   32'h0, 32'h0, 2'b01, 4'b0, 32'h0);
    single(1'b0, 3'b001, 32'h01,   32'h0, 32'h0, 2'b01, 4'b0, 32'h0);
    single(1'b1, 3'b010, 32'h1000, 32'h11111111, 32'h0, 2'b10, 4'b0, 32'h0);
    single(1'b0, 3'b011, 32'h00,   32'h0, 32'h0, 2'b11, 4'b0, 32'h0);
    single(1'b1, 3'b100, 32'h00,   32'h0, 32'h0, 2'b11, 4'b0, 32'h0);
    single(1'b0, 3'b111, 32'h01,   32'h0, 32'h0, 2'b11, 4'b0, 32'h0);
    single(1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 2'b01, 4'b0, 32'h0);

    // Top of the address range.
    single(1'b1, 3'b010, 32'hFFC, 32'h5A5A1234, 32'h0, 2'b00, 4'b1111, 32'h5A5A1234);
    single(1'b0, 3'b010, 32'hFFC, 32'h0, 32'h5A5A1234, 2'b00, 4'b0, 32'h0);
    single(1'b0, 3'b000, 32'hFFF, 32'h0, 32'h0000005A, 2'b00, 4'b0, 32'h0);

    // Back-to-back with req_valid held high.
    issue(1'b1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 2'b00, 4'b1111, 32'hCAFEF00D, c1);
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 2'b00, 4'b0, 32'h0, c2);
    issue(1'b0, 3'b100, 32'h1, 32'h0, 32'h000000F0, 2'b00, 4'b0, 32'h0, c3);
    req_valid = 1'b0;
    check("b2b_gap1", c2 - c1, 32'd3);
    check("b2b_gap2", c3 - c2, 32'd3);
    drain();

    // Reset during WAIT discards the pending response.
    issue(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 2'b00, 4'b0, 32'h0, c1);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'h0, req_ready}, 32'd1);
    repeat (2) @(posedge clka);
    #1;
    check("mid_rst_resp_valid_hold", {31'h0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    check("post_rst_ready", {31'h0, req_ready}, 32'd1);
    single(1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 2'b00, 4'b0, 32'h0);

    repeat (3) @(posedge clka);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
